// File: rtl/nic_pkg.sv
// Shared definitions for the NIC PE port: register addresses and packet field positions.
// Packet bits use big-endian numbering [0:63]; bit 0 is the vc bit.
package nic_pkg;

    localparam int NIC_DW = 64;

    typedef enum logic [1:0] {
        INPUT_BUFFER  = 2'b00,
        INPUT_STATUS  = 2'b01,
        OUTPUT_BUFFER = 2'b10,
        OUTPUT_STATUS = 2'b11
    } nic_addr_e;

    localparam int VC_IDX        = 0;
    localparam int DIR_IDX       = 1;
    localparam int HOP_FIRST     = 8;
    localparam int HOP_LAST      = 15;
    localparam int SRC_FIRST     = 16;
    localparam int SRC_LAST      = 31;
    localparam int PAYLOAD_FIRST = 32;
    localparam int PAYLOAD_LAST  = 63;

endpackage

// File: rtl/nic_pe_port_if.sv
// PE register bus plus router injection/ejection signals of one NIC port.
// master: the PE and router side; slave: the NIC.
interface nic_pe_port_if #(parameter int DW = 64);
    logic [0:1]    addr;
    logic [0:DW-1] d_in;
    logic [0:DW-1] d_out;
    logic          nicEn;
    logic          nicWrEn;
    logic          net_so;
    logic          net_ro;
    logic [0:DW-1] net_do;
    logic          net_polarity;
    logic          net_si;
    logic          net_ri;
    logic [0:DW-1] net_di;

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );
endinterface

// File: rtl/nic_slot.sv
// One-entry packet slot: a full flag and a data register.
// Clearing only drops the full flag; the data stays visible until the next load.
// A load in the same cycle as a clear wins, so a captured packet is never lost.
module nic_slot #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clr,
    input  logic [0:DW-1] din,
    output logic          full,
    output logic [0:DW-1] data
);
    logic          full_q, full_d;
    logic [0:DW-1] data_q, data_d;

    // Next slot contents from load/clear requests
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clr) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d = 1'b1;
            data_d = din;
        end
    end

    // Slot registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;
endmodule

// File: rtl/nic_pe_port.sv
// NIC PE-side register port with one-entry outbound and inbound slots.
// Injection is allowed only when the packet's vc bit matches the ring polarity.
// Optional macro NIC_DOUT_REG_EN: registers d_out (one cycle read latency).
module nic_pe_port
    import nic_pkg::*;
#(
    parameter int DW = 64
) (
    input logic           clk,
    input logic           reset,
    nic_pe_port_if.slave  bus
);
    logic          pe_rd, pe_wr;
    logic          ob_load, ob_clr, ob_full;
    logic [0:DW-1] ob_data;
    logic          ib_load, ib_clr, ib_full;
    logic [0:DW-1] ib_data;
    logic          net_so_c;
    logic [0:DW-1] rd_data;
    nic_addr_e     addr_e;

    // PE access decode and network handshake gating
    always_comb begin
        addr_e   = nic_addr_e'(bus.addr);
        pe_rd    = bus.nicEn & ~bus.nicWrEn;
        pe_wr    = bus.nicEn & bus.nicWrEn;
        // a write is judged against the full flag before the edge, so it
        // is dropped even when the slot drains at that same edge
        ob_load  = pe_wr & (addr_e == OUTPUT_BUFFER) & ~ob_full;
        net_so_c = ob_full & bus.net_ro & (ob_data[VC_IDX] == bus.net_polarity);
        ob_clr   = net_so_c;
        // capture is gated by net_ri, so a packet arriving during a 00 read
        // waits until the cycle after the slot drains
        ib_load  = bus.net_si & ~ib_full;
        ib_clr   = pe_rd & (addr_e == INPUT_BUFFER);
    end

    nic_slot #(.DW(DW)) u_ob_slot (
        .clk   (clk),
        .reset (reset),
        .load  (ob_load),
        .clr   (ob_clr),
        .din   (bus.d_in),
        .full  (ob_full),
        .data  (ob_data)
    );

    nic_slot #(.DW(DW)) u_ib_slot (
        .clk   (clk),
        .reset (reset),
        .load  (ib_load),
        .clr   (ib_clr),
        .din   (bus.net_di),
        .full  (ib_full),
        .data  (ib_data)
    );

    // PE read mux; status words carry the full flag in the last bit
    always_comb begin
        rd_data = '0;
        if (pe_rd) begin
            case (addr_e)
                INPUT_BUFFER:  rd_data = ib_data;
                INPUT_STATUS:  rd_data[DW-1] = ib_full;
                OUTPUT_BUFFER: rd_data = ob_data;
                OUTPUT_STATUS: rd_data[DW-1] = ob_full;
                default:       rd_data = '0;
            endcase
        end
    end

`ifdef NIC_DOUT_REG_EN
    logic [0:DW-1] dout_q, dout_d;

    // Registered read data: the value sampled before any clear at this edge
    always_comb begin
        dout_d = rd_data;
    end

    // Read data register
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.d_out = dout_q;
`else
    assign bus.d_out = rd_data;
`endif

    assign bus.net_so = net_so_c;
    assign bus.net_do = ob_data;
    assign bus.net_ri = ~ib_full;
endmodule

// File: tb/tb_nic_pe_port.sv
// Directed bench for nic_pe_port (default build, combinational d_out).
module tb_nic_pe_port;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [63:0] exp_q[$];

    localparam logic [1:0] A_IB = 2'b00;
    localparam logic [1:0] A_IS = 2'b01;
    localparam logic [1:0] A_OB = 2'b10;
    localparam logic [1:0] A_OS = 2'b11;

    localparam logic [63:0] P1  = 64'h0001_0000_0000_0003;
    localparam logic [63:0] P2  = 64'h0002_0000_0000_0055;
    localparam logic [63:0] PA  = 64'h0000_0000_0000_0011;
    localparam logic [63:0] PB  = 64'h0000_0000_0000_00AA;
    localparam logic [63:0] PE  = 64'h8001_0002_0000_0001;
    localparam logic [63:0] Q1  = 64'h0000_0001_0000_00C1;
    localparam logic [63:0] Q2  = 64'h8000_0002_0000_00C2;
    localparam logic [63:0] Q3  = 64'h0000_0003_0000_00C3;
    localparam logic [63:0] PX  = 64'h0000_0004_0000_00D4;

    nic_pe_port_if #(.DW(64)) bus ();

    nic_pe_port #(.DW(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.nicEn   = 1'b0;
        bus.nicWrEn = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        bus.addr    = a;
        bus.d_in    = d;
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b1;
    endtask

    // drive a read, queue its expected data, compare at mid-cycle
    task automatic rd(input logic [1:0] a, input logic [63:0] e, input string tag);
        bus.addr    = a;
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        chk(tag, bus.d_out, exp_q.pop_front());
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.addr = 2'b00;
        bus.d_in = '0;
        bus.nicEn = 1'b0;
        bus.nicWrEn = 1'b0;
        bus.net_ro = 1'b0;
        bus.net_polarity = 1'b0;
        bus.net_si = 1'b0;
        bus.net_di = '0;

        // reset
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        sample();
        chk("rst_dout", bus.d_out, 64'd0);
        chk("rst_net_so", {63'd0, bus.net_so}, 64'd0);
        chk("rst_net_ri", {63'd0, bus.net_ri}, 64'd1);
        chk("rst_net_do", bus.net_do, 64'd0);
        tick();
        rd(A_OS, 64'd0, "rst_ob_status"); tick();
        rd(A_IS, 64'd0, "rst_ib_status"); tick();

        // inject on matching phase
        bus.net_ro = 1'b1;
        bus.net_polarity = 1'b1;
        wr(A_OB, P1);
        sample();
        chk("inj_so_empty", {63'd0, bus.net_so}, 64'd0);
        tick();
        rd(A_OS, 64'd1, "inj_status_full");
        chk("inj_so_mismatch", {63'd0, bus.net_so}, 64'd0);
        chk("inj_net_do", bus.net_do, P1);
        tick();
        bus.net_polarity = 1'b0;
        wr(A_OB, P2);
        sample();
        chk("inj_so_match", {63'd0, bus.net_so}, 64'd1);
        chk("inj_net_do_match", bus.net_do, P1);
        tick();
        bus.net_polarity = 1'b1;
        rd(A_OS, 64'd0, "inj_status_freed");
        chk("inj_so_after", {63'd0, bus.net_so}, 64'd0);
        chk("inj_write_dropped", bus.net_do, P1);
        tick();

        // blocked inject
        bus.net_ro = 1'b0;
        bus.net_polarity = 1'b0;
        wr(A_OB, PA); tick();
        wr(A_OB, PB); tick();
        rd(A_OS, 64'd1, "blk_status");
        chk("blk_net_do", bus.net_do, PA);
        chk("blk_net_so", {63'd0, bus.net_so}, 64'd0);
        tick();
        rd(A_OB, PA, "blk_ob_read"); tick();
        bus.net_ro = 1'b1;
        sample();
        chk("blk_release_so", {63'd0, bus.net_so}, 64'd1);
        tick();
        bus.net_ro = 1'b0;
        rd(A_OS, 64'd0, "blk_status_freed"); tick();

        // writes to non-buffer addresses are ignored
        wr(A_IS, 64'hFFFF_FFFF_FFFF_FFFF); tick();
        wr(A_OS, 64'hFFFF_FFFF_FFFF_FFFF); tick();
        rd(A_OS, 64'd0, "ign_os"); tick();
        rd(A_IS, 64'd0, "ign_is"); tick();

        // eject and clear
        bus.net_si = 1'b1;
        bus.net_di = PE;
        sample();
        chk("ej_ri_before", {63'd0, bus.net_ri}, 64'd1);
        tick();
        bus.net_si = 1'b0;
        bus.net_di = '0;
        rd(A_IS, 64'd1, "ej_status");
        chk("ej_ri_full", {63'd0, bus.net_ri}, 64'd0);
        tick();
        sample();
        chk("idle_dout", bus.d_out, 64'd0);
        tick();
        rd(A_IB, PE, "ej_read"); tick();
        rd(A_IS, 64'd0, "ej_cleared");
        chk("ej_ri_after", {63'd0, bus.net_ri}, 64'd1);
        tick();

        // back-pressure
        bus.net_si = 1'b1;
        bus.net_di = Q1;
        tick();
        bus.net_di = Q2;
        sample();
        chk("bp_ri_held", {63'd0, bus.net_ri}, 64'd0);
        tick();
        tick();
        rd(A_IS, 64'd1, "bp_status_full"); tick();
        rd(A_IB, Q1, "bp_first");
        chk("bp_ri_on_read", {63'd0, bus.net_ri}, 64'd0);
        tick();
        rd(A_IS, 64'd0, "bp_gap_status");
        chk("bp_ri_gap", {63'd0, bus.net_ri}, 64'd1);
        tick();
        bus.net_si = 1'b0;
        bus.net_di = '0;
        rd(A_IS, 64'd1, "bp_second_status"); tick();
        rd(A_IB, Q2, "bp_second"); tick();

        // reset mid-operation
        bus.net_ro = 1'b0;
        wr(A_OB, PX);
        bus.net_si = 1'b1;
        bus.net_di = Q3;
        tick();
        bus.net_si = 1'b0;
        rd(A_OS, 64'd1, "mid_ob_full"); tick();
        rd(A_IS, 64'd1, "mid_ib_full"); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.net_ro = 1'b1;
        bus.net_polarity = 1'b0;
        rd(A_OS, 64'd0, "mid_rst_ob_status");
        chk("mid_rst_so", {63'd0, bus.net_so}, 64'd0);
        chk("mid_rst_ri", {63'd0, bus.net_ri}, 64'd1);
        chk("mid_rst_net_do", bus.net_do, 64'd0);
        tick();
        rd(A_IS, 64'd0, "mid_rst_ib_status"); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
